// File: rtl/i2s_mic_emulator.sv
// I2S slave transmitter that follows an external SCK/WS and sends stereo samples MSB first on SD.
// Each stereo frame is taken from a one-frame holding buffer, which a valid/ready handshake fills.
module i2s_mic_emulator #(
  parameter int DATA_WIDTH = 18,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  output logic                  i2s_sd,
  input  logic [DATA_WIDTH-1:0] sample_l,
  input  logic [DATA_WIDTH-1:0] sample_r,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] BIT_SAT = CNT_W'(DATA_WIDTH);

  logic [1:0]            sck_sync_reg;
  logic                  sck_hist_reg;
  logic [1:0]            ws_sync_reg;
  logic                  ws_last_reg;

  logic [DATA_WIDTH-1:0] hold_l_reg, hold_l_next;
  logic [DATA_WIDTH-1:0] hold_r_reg, hold_r_next;
  logic                  hold_full_reg, hold_full_next;
  logic [DATA_WIDTH-1:0] frame_l_reg, frame_l_next;
  logic [DATA_WIDTH-1:0] frame_r_reg, frame_r_next;
  logic                  underrun_next;

  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  sd_reg, sd_next;
  logic                  frame_start_reg, underrun_reg;

  logic sck_fall;
  logic ws_now;
  logic slot_start;
  logic left_start;
  logic transfer;

  assign sck_fall   = sck_hist_reg & ~sck_sync_reg[1];
  assign ws_now     = ws_sync_reg[1];
  assign slot_start = sck_fall & (ws_now != ws_last_reg);
  assign left_start = slot_start & ~ws_now;
  assign transfer   = sample_valid & ~hold_full_reg;

  assign sample_ready = ~hold_full_reg;
  assign i2s_sd       = sd_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;

  // Both pins go through the same flop depth so that WS stays aligned with the SCK edge it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync_reg <= 2'b11;
      sck_hist_reg <= 1'b1;
      ws_sync_reg  <= 2'b11;
    end else begin
      sck_sync_reg <= {sck_sync_reg[0], i2s_sck};
      sck_hist_reg <= sck_sync_reg[1];
      ws_sync_reg  <= {ws_sync_reg[0], i2s_ws};
    end
  end

  always_comb begin
    hold_l_next    = hold_l_reg;
    hold_r_next    = hold_r_reg;
    hold_full_next = hold_full_reg;
    frame_l_next   = frame_l_reg;
    frame_r_next   = frame_r_reg;
    underrun_next  = 1'b0;

    if (transfer) begin
      hold_l_next    = sample_l;
      hold_r_next    = sample_r;
      hold_full_next = 1'b1;
    end

    // A frame offered in the very cycle the left slot opens bypasses the holding buffer.
    if (left_start) begin
      if (hold_full_reg) begin
        frame_l_next   = hold_l_reg;
        frame_r_next   = hold_r_reg;
        hold_full_next = 1'b0;
      end else if (transfer) begin
        frame_l_next   = sample_l;
        frame_r_next   = sample_r;
        hold_full_next = 1'b0;
      end else begin
        frame_l_next  = '0;
        frame_r_next  = '0;
        underrun_next = 1'b1;
      end
    end
  end

  always_comb begin
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    sd_next      = sd_reg;

    if (slot_start) begin
      bit_cnt_next = '0;
      shreg_next   = ws_now ? frame_r_reg : frame_l_next;
      sd_next      = 1'b0;
    end else if (sck_fall) begin
      if (bit_cnt_reg < BIT_SAT) begin
        sd_next      = shreg_reg[DATA_WIDTH-1];
        shreg_next   = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
      end else begin
        sd_next      = 1'b0;
        bit_cnt_next = BIT_SAT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_last_reg     <= 1'b1;
      hold_l_reg      <= '0;
      hold_r_reg      <= '0;
      hold_full_reg   <= 1'b0;
      frame_l_reg     <= '0;
      frame_r_reg     <= '0;
      shreg_reg       <= '0;
      bit_cnt_reg     <= BIT_SAT;
      sd_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      if (slot_start) begin
        ws_last_reg <= ws_now;
      end
      hold_l_reg      <= hold_l_next;
      hold_r_reg      <= hold_r_next;
      hold_full_reg   <= hold_full_next;
      frame_l_reg     <= frame_l_next;
      frame_r_reg     <= frame_r_next;
      shreg_reg       <= shreg_next;
      bit_cnt_reg     <= bit_cnt_next;
      sd_reg          <= sd_next;
      frame_start_reg <= left_start;
      underrun_reg    <= underrun_next;
    end
  end

endmodule

// File: tb/tb_i2s_mic_emulator.sv
// Drives i2s_mic_emulator as an I2S master and captures SD on rising SCK.
// Captured words are compared with a time-stamped frame queue model.
`timescale 1ns/1ps
module tb_i2s_mic_emulator;
  localparam int DW   = 18;
  localparam int SW   = 32;
  localparam int HALF = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i2s_sck = 1'b1;
  logic          i2s_ws = 1'b1;
  logic          i2s_sd;
  logic [DW-1:0] sample_l = '0;
  logic [DW-1:0] sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          frame_start;
  logic          underrun;

  i2s_mic_emulator #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Posedge counter: an edge is named by the value cyc takes after it.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int fs_cnt = 0;
  int ur_cnt = 0;
  always @(negedge clock) begin
    if (frame_start === 1'b1) fs_cnt++;
    if (underrun === 1'b1) ur_cnt++;
  end

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int rel; } offer_t;
  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int at; } acc_t;
  offer_t offer_q[$];
  acc_t   acc_q[$];
  int     left_edge = -10;
  int     exp_fs = 0;
  int     exp_ur = 0;
  int     frame_no = 0;

  function automatic void push_offer(input logic [DW-1:0] l, input logic [DW-1:0] r, input int rel);
    offer_t o;
    o.l = l; o.r = r; o.rel = rel;
    offer_q.push_back(o);
  endfunction

  // Producer: offers queue head once released; records the edge each transfer happens on.
  initial begin : producer
    bit   pending;
    int   xfer_at;
    acc_t a;
    pending = 0;
    xfer_at = 0;
    forever begin
      @(negedge clock);
      if (pending) begin
        a.l = offer_q[0].l; a.r = offer_q[0].r; a.at = xfer_at;
        acc_q.push_back(a);
        void'(offer_q.pop_front());
        check("ready_after_accept", 64'(sample_ready), (xfer_at == left_edge) ? 64'd1 : 64'd0);
        pending = 0;
      end
      if (offer_q.size() > 0 && cyc + 1 >= offer_q[0].rel) begin
        sample_valid = 1'b1;
        sample_l = offer_q[0].l;
        sample_r = offer_q[0].r;
        pending = sample_ready;
        xfer_at = cyc + 1;
      end else begin
        sample_valid = 1'b0;
        sample_l = DW'($urandom);
        sample_r = DW'($urandom);
      end
    end
  end

  task automatic run_slot(input logic ws_val, input int nbits, input int rst_at, input bit byp,
                          input logic [DW-1:0] bl, input logic [DW-1:0] br,
                          output logic [63:0] bits, output int start_edge);
    bits = '0;
    start_edge = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      i2s_sck = 1'b0;
      if (i == 0) begin
        i2s_ws = ws_val;
        start_edge = cyc + 3;
        if (!ws_val) left_edge = start_edge;
        if (byp) push_offer(bl, br, start_edge);
      end
      for (int c = 1; c < HALF; c++) begin
        @(negedge clock);
        if (i == rst_at && c == 5) reset = 1'b1;
        if (i == rst_at && c == 6) begin
          check("sd_after_reset", 64'(i2s_sd), 64'd0);
          reset = 1'b0;
        end
      end
      @(negedge clock);
      i2s_sck = 1'b1;
      bits[i] = i2s_sd;
      repeat (HALF - 1) @(negedge clock);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [63:0] bits, input int kept);
    logic [63:0] w;
    w = '0;
    for (int j = 1; j <= kept; j++) w = (w << 1) | 64'(bits[j]);
    return w;
  endfunction

  task automatic run_frame(input int nl, input int nr, input int rst_at, input bit byp,
                           input logic [DW-1:0] bl, input logic [DW-1:0] br);
    logic [63:0] lbits, rbits, mask;
    int s_l, s_r, kept_l, kept_r;
    logic [DW-1:0] el, er;
    run_slot(1'b0, nl, rst_at, byp, bl, br, lbits, s_l);
    exp_fs++;
    if (acc_q.size() > 0 && acc_q[0].at <= s_l) begin
      el = acc_q[0].l; er = acc_q[0].r;
      void'(acc_q.pop_front());
    end else begin
      el = '0; er = '0;
      exp_ur++;
    end
    kept_l = (nl - 1 < DW) ? nl - 1 : DW;
    if (rst_at >= 0) begin
      // Reset mid-slot: the resynchronised WS opens a fresh left slot with nothing buffered.
      kept_l = rst_at - 1;
      exp_fs++;
      exp_ur++;
      er = '0;
    end
    check("left_word", word_of(lbits, kept_l), 64'(el) >> (DW - kept_l));
    mask = ((64'd1 << kept_l) - 64'd1) << 1;
    check("left_pad", lbits & ~mask, 64'd0);

    run_slot(1'b1, nr, -1, 1'b0, '0, '0, rbits, s_r);
    kept_r = (nr - 1 < DW) ? nr - 1 : DW;
    check("right_word", word_of(rbits, kept_r), 64'(er) >> (DW - kept_r));
    mask = ((64'd1 << kept_r) - 64'd1) << 1;
    check("right_pad", rbits & ~mask, 64'd0);
    check("frame_start_cnt", 64'(fs_cnt), 64'(exp_fs));
    check("underrun_cnt", 64'(ur_cnt), 64'(exp_ur));
    frame_no++;
    $display("frame %0d: L=%05h R=%05h (expected %05h %05h) fs=%0d ur=%0d", frame_no,
             word_of(lbits, kept_l), word_of(rbits, kept_r), el, er, fs_cnt, ur_cnt);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] base;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_sd", 64'(i2s_sd), 64'd0);
    check("reset_ready", 64'(sample_ready), 64'd1);
    check("reset_frame_start", 64'(frame_start), 64'd0);
    check("reset_underrun", 64'(underrun), 64'd0);

    // Known pattern loaded ahead of the first left slot.
    push_offer(18'h2A5C3, 18'h15A3C, 0);
    run_frame(SW, SW, -1, 1'b0, '0, '0);

    // Nothing offered: underrun, zeros sent; then a fresh frame.
    run_frame(SW, SW, -1, 1'b0, '0, '0);
    push_offer(DW'($urandom), DW'($urandom), 0);
    run_frame(SW, SW, -1, 1'b0, '0, '0);

    // Offer lands exactly on the left slot start edge.
    run_frame(SW, SW, -1, 1'b1, 18'h00001, 18'h3FFFF);

    // Continuous producer with incrementing left samples.
    base = DW'($urandom);
    for (int k = 0; k < 4; k++) push_offer(base + DW'(k), DW'($urandom), 0);
    for (int k = 0; k < 4; k++) run_frame(SW, SW, -1, 1'b0, '0, '0);

    // Reset at bit 7 of a full-scale left word, then a normal frame.
    push_offer(18'h3FFFF, DW'($urandom), 0);
    run_frame(SW, SW, 7, 1'b0, '0, '0);
    push_offer(DW'($urandom), DW'($urandom), 0);
    run_frame(SW, SW, -1, 1'b0, '0, '0);

    // Left slot cut to 10 SCKs, then a normal frame.
    push_offer(18'h3FFFF, DW'($urandom), 0);
    run_frame(10, SW, -1, 1'b0, '0, '0);
    push_offer(DW'($urandom), DW'($urandom), 0);
    run_frame(SW, SW, -1, 1'b0, '0, '0);

    // Random mix of offered and missing frames.
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 3) != 0) push_offer(DW'($urandom), DW'($urandom), 0);
      run_frame(SW, SW, -1, 1'b0, '0, '0);
    end

    check("offers_drained", 64'(offer_q.size()), 64'd0);
    check("accepted_drained", 64'(acc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
